// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage
// Purpose  : Operand issue / writeback stage around a combinational ALU,
//            owning the 32x32 register file with full EX/WB forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_stage #(
    parameter int NREG = 32,
    parameter int DW   = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          hold,
    input  logic [4:0]    in_rs,
    input  logic [4:0]    in_rt,
    input  logic [4:0]    in_rd,
    input  logic [DW-1:0] in_imm,
    input  logic          in_use_imm,
    input  logic [2:0]    in_op,
    output logic [DW-1:0] A,
    output logic [DW-1:0] B,
    output logic [2:0]    ALUOp,
    input  logic [DW-1:0] C,
    output logic          wb_valid,
    output logic [4:0]    wb_rd,
    output logic [DW-1:0] wb_data,
    input  logic [4:0]    dbg_addr,
    output logic [DW-1:0] dbg_data
);

    localparam logic [4:0] c_REG0 = 5'd0;

    logic [DW-1:0] r_regs [NREG];

    logic          r_ex_valid;
    logic [4:0]    r_ex_rd;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [2:0]    r_op;

    logic          r_wb_valid;
    logic [4:0]    r_wb_rd;
    logic [DW-1:0] r_wb_data;

    logic          w_accept;
    logic [DW-1:0] w_rs_val;
    logic [DW-1:0] w_rt_val;
    logic [DW-1:0] w_b_next;

    // EX forwarding beats WB forwarding, which beats the (possibly stale) array.
    function automatic logic [DW-1:0] read_src(
        input logic [4:0]    s,
        input logic [DW-1:0] arr_val,
        input logic          ex_v,
        input logic [4:0]    ex_rd,
        input logic [DW-1:0] ex_res,
        input logic          wb_v,
        input logic [4:0]    wb_idx,
        input logic [DW-1:0] wb_val
    );
        logic [DW-1:0] v;
        if (s == c_REG0)
            v = '0;
        else if (ex_v && (ex_rd == s))
            v = ex_res;
        else if (wb_v && (wb_idx == s))
            v = wb_val;
        else
            v = arr_val;
        return v;
    endfunction

    assign in_ready = ~hold;
    assign w_accept = in_valid & ~hold;

    always_comb begin
        w_rs_val = read_src(in_rs, r_regs[in_rs], r_ex_valid, r_ex_rd, C,
                            r_wb_valid, r_wb_rd, r_wb_data);
        w_rt_val = read_src(in_rt, r_regs[in_rt], r_ex_valid, r_ex_rd, C,
                            r_wb_valid, r_wb_rd, r_wb_data);
        w_b_next = in_use_imm ? in_imm : w_rt_val;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ex_valid <= 1'b0;
            r_ex_rd    <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= '0;
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            for (int i = 0; i < NREG; i++)
                r_regs[i] <= '0;
        end else if (!hold) begin
            if (w_accept) begin
                r_ex_valid <= 1'b1;
                r_ex_rd    <= in_rd;
                r_a        <= w_rs_val;
                r_b        <= w_b_next;
                r_op       <= in_op;
            end else begin
                r_ex_valid <= 1'b0;
            end
            r_wb_valid <= r_ex_valid;
            r_wb_rd    <= r_ex_rd;
            r_wb_data  <= C;
            if (r_wb_valid && (r_wb_rd != c_REG0))
                r_regs[r_wb_rd] <= r_wb_data;
        end
    end

    assign A        = r_a;
    assign B        = r_b;
    assign ALUOp    = r_op;
    assign wb_valid = r_wb_valid;
    assign wb_rd    = r_wb_rd;
    assign wb_data  = r_wb_data;
    assign dbg_data = (dbg_addr == c_REG0) ? '0 : r_regs[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_stage
// Purpose  : Directed and random checks of alu_issue_stage against an
//            architectural register-file model with a behavioural ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic        hold;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [31:0] in_imm;
    logic        in_use_imm;
    logic [2:0]  in_op;
    logic [31:0] A, B, C;
    logic [2:0]  ALUOp;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int n_asserts = 0;
    int n_fail    = 0;

    // Architectural state: every accepted op is applied immediately, since
    // forwarding makes the pipeline invisible to later reads.
    logic [31:0] m_regs [32];
    logic [31:0] exp_a, exp_b, exp_ex_res, exp_wb_data;
    logic [2:0]  exp_op;
    logic        exp_ex_valid, exp_wb_valid;
    logic [4:0]  exp_ex_rd, exp_wb_rd;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a >> b[4:0];
            3'd5: return $unsigned($signed(a) >>> b[4:0]);
            3'd6: return a ^ b;
            default: return {31'd0, (a < b)};
        endcase
    endfunction

    assign C = alu(A, B, ALUOp);

    alu_issue_stage #(.NREG(32), .DW(32)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .hold(hold), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .in_use_imm(in_use_imm), .in_op(in_op),
        .A(A), .B(B), .ALUOp(ALUOp), .C(C),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("A", A, exp_a);
        chk("B", B, exp_b);
        chk("ALUOp", {29'd0, ALUOp}, {29'd0, exp_op});
        chk("wb_valid", {31'd0, wb_valid}, {31'd0, exp_wb_valid});
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, exp_wb_rd});
        chk("wb_data", wb_data, exp_wb_data);
    endtask

    task automatic check_regs();
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            chk($sformatf("dbg_r%0d", i), dbg_data, (i == 0) ? 32'd0 : m_regs[i]);
        end
    endtask

    task automatic cycle(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] imm, input logic ui,
                         input logic [2:0] op, input logic h);
        logic [31:0] a, b;
        in_valid = v; in_rs = rs; in_rt = rt; in_rd = rd;
        in_imm = imm; in_use_imm = ui; in_op = op; hold = h;
        #1;
        chk("in_ready", {31'd0, in_ready}, {31'd0, ~h});
        @(posedge clk);
        #1;
        if (!h) begin
            exp_wb_valid = exp_ex_valid;
            exp_wb_rd    = exp_ex_rd;
            exp_wb_data  = exp_ex_res;
            if (v) begin
                a = (rs == 5'd0) ? 32'd0 : m_regs[rs];
                b = ui ? imm : ((rt == 5'd0) ? 32'd0 : m_regs[rt]);
                exp_a = a; exp_b = b; exp_op = op;
                exp_ex_valid = 1'b1;
                exp_ex_rd    = rd;
                exp_ex_res   = alu(a, b, op);
                if (rd != 5'd0) m_regs[rd] = exp_ex_res;
            end else begin
                exp_ex_valid = 1'b0;
            end
        end
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        in_valid = 1'b0; hold = 1'b0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        exp_a = 0; exp_b = 0; exp_op = 0; exp_ex_res = 0; exp_wb_data = 0;
        exp_ex_valid = 0; exp_wb_valid = 0; exp_ex_rd = 0; exp_wb_rd = 0;
        #1;
        check_outputs();
        check_regs();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 0; hold = 0; in_rs = 0; in_rt = 0; in_rd = 0;
        in_imm = 0; in_use_imm = 0; in_op = 0; dbg_addr = 0;
        #2;
        do_reset();

        // Back-to-back forwarding chain
        cycle(1, 5'd0, 5'd0, 5'd1, 32'd5, 1, 3'b000, 0);
        chk("fwd_A0", A, 32'd0); chk("fwd_B0", B, 32'd5);
        cycle(1, 5'd1, 5'd0, 5'd2, 32'd3, 1, 3'b001, 0);
        chk("fwd_A1", A, 32'd5); chk("fwd_B1", B, 32'd3); chk("fwd_wb0", wb_data, 32'd5);
        cycle(1, 5'd2, 5'd1, 5'd3, 32'd0, 0, 3'b010, 0);
        chk("fwd_A2", A, 32'd2); chk("fwd_B2", B, 32'd5); chk("fwd_wb1", wb_data, 32'd2);
        idle(1);
        chk("fwd_wb2", wb_data, 32'd0);
        idle(2);
        dbg_addr = 5'd1; #1; chk("r1", dbg_data, 32'd5);
        dbg_addr = 5'd2; #1; chk("r2", dbg_data, 32'd2);
        dbg_addr = 5'd3; #1; chk("r3", dbg_data, 32'd0);

        // Register-0 discard
        cycle(1, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 1, 3'b000, 0);
        cycle(1, 5'd0, 5'd0, 5'd4, 32'd0, 0, 3'b011, 0);
        chk("r0_wbv", {31'd0, wb_valid}, 32'd1); chk("r0_wbrd", {27'd0, wb_rd}, 32'd0);
        chk("r0_A", A, 32'd0); chk("r0_B", B, 32'd0);
        idle(3);
        check_regs();

        // Hold with an op in EX
        cycle(1, 5'd1, 5'd2, 5'd8, 32'd0, 0, 3'b110, 0);
        for (int i = 0; i < 3; i++) cycle(1, 5'd3, 5'd3, 5'd9, 32'd7, 1, 3'b000, 1);
        cycle(0, 5'd0, 5'd0, 5'd0, 32'd0, 0, 3'd0, 0);
        chk("hold_wb", wb_data, 32'd7);
        cycle(0, 5'd0, 5'd0, 5'd0, 32'd0, 0, 3'd0, 0);
        chk("hold_nodup", {31'd0, wb_valid}, 32'd0);
        idle(2);

        // Shifts
        cycle(1, 5'd0, 5'd0, 5'd5, 32'h8000_0000, 1, 3'b000, 0);
        cycle(1, 5'd5, 5'd0, 5'd6, 32'd4, 1, 3'b101, 0);
        cycle(1, 5'd5, 5'd0, 5'd7, 32'd4, 1, 3'b100, 0);
        chk("sra", wb_data, 32'hF800_0000);
        idle(1);
        chk("srl", wb_data, 32'h0800_0000);
        idle(2);
        check_regs();

        // Bubble: two idle cycles between ops
        cycle(1, 5'd6, 5'd7, 5'd10, 32'd0, 0, 3'b011, 0);
        idle(2);
        chk("bub_A", A, 32'hF800_0000); chk("bub_B", B, 32'h0800_0000);
        cycle(1, 5'd10, 5'd0, 5'd11, 32'd1, 1, 3'b000, 0);
        idle(3);

        // Random traffic with tight register reuse
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom % 4) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), $urandom, 1'($urandom), 3'($urandom),
                  ($urandom % 8) == 0);
        end
        idle(3);
        check_regs();

        // Reset in the middle of in-flight operations
        cycle(1, 5'd0, 5'd0, 5'd12, 32'd99, 1, 3'b000, 0);
        cycle(1, 5'd12, 5'd0, 5'd13, 32'd1, 1, 3'b000, 0);
        #2;
        do_reset();
        idle(3);
        check_regs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
